// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the registered ALU.
//   alu_op_t    - 4-bit opcode; codes 11..15 are reserved.
//   alu_flags_t - packed {n, z, v, c} flag bundle.
//   alu_state_t - control states of alu_registrada.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_XOR    = 4'd4,
        OP_NOT    = 4'd5,
        OP_SHL    = 4'd6,
        OP_SHR    = 4'd7,
        OP_ASR    = 4'd8,
        OP_MUL    = 4'd9,
        OP_PASS_B = 4'd10
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } alu_flags_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_DONE     = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational single-cycle datapath of the registered ALU.
// Ports:
//   i_a, i_b   operands (shift amount = i_b[SHW-1:0])
//   i_op       opcode
//   o_result   result
//   o_flags    N/Z/V/C
//   o_illegal  opcode is reserved (includes MUL, which the top handles itself)
module alu_comb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  alu_op_t          i_op,
    output logic [WIDTH-1:0] o_result,
    output alu_flags_t       o_flags,
    output logic             o_illegal
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned MSB = WIDTH - 1;

    logic [SHW-1:0] w_sh;
    logic [WIDTH:0] w_ext;
    logic [WIDTH-1:0] w_res;
    logic           w_v;
    logic           w_c;
    logic           w_ill;

    assign w_sh = i_b[SHW-1:0];

    // w_ext is one bit wider than the operands: it carries the carry/borrow
    // for ADD/SUB and the last bit shifted out for the shifts, so a shift
    // amount of zero yields C=0 with no special case.
    always_comb begin
        w_ext = '0;
        w_res = '0;
        w_v   = 1'b0;
        w_c   = 1'b0;
        w_ill = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_ext = {1'b0, i_a} + {1'b0, i_b};
                w_res = w_ext[WIDTH-1:0];
                w_c   = w_ext[WIDTH];
                w_v   = (i_a[MSB] == i_b[MSB]) && (w_res[MSB] != i_a[MSB]);
            end
            OP_SUB: begin
                w_ext = {1'b0, i_a} - {1'b0, i_b};
                w_res = w_ext[WIDTH-1:0];
                w_c   = ~w_ext[WIDTH];
                w_v   = (i_a[MSB] != i_b[MSB]) && (w_res[MSB] != i_a[MSB]);
            end
            OP_AND:    w_res = i_a & i_b;
            OP_OR:     w_res = i_a | i_b;
            OP_XOR:    w_res = i_a ^ i_b;
            OP_NOT:    w_res = ~i_a;
            OP_PASS_B: w_res = i_b;
            OP_SHL: begin
                w_ext = {1'b0, i_a} << w_sh;
                w_res = w_ext[WIDTH-1:0];
                w_c   = w_ext[WIDTH];
            end
            OP_SHR: begin
                w_ext = {i_a, 1'b0} >> w_sh;
                w_res = w_ext[WIDTH:1];
                w_c   = w_ext[0];
            end
            OP_ASR: begin
                w_ext = $unsigned($signed({i_a, 1'b0}) >>> w_sh);
                w_res = w_ext[WIDTH:1];
                w_c   = w_ext[0];
            end
            // Reserved codes and MUL: result 0, illegal.
            default: w_ill = 1'b1;
        endcase
    end

    always_comb begin
        o_result  = w_res;
        o_illegal = w_ill;
        o_flags   = '{n: w_res[MSB], z: (w_res == '0), v: w_v, c: w_c};
    end

endmodule

// File: rtl/alu_registrada.sv
// alu_registrada: registered ALU with valid/ready handshake on both sides.
// Single-cycle ops complete the cycle after accept; the optional multiplier
// iterates one shift-add step per clock. Result, flags and illegal are held
// stable while the consumer applies backpressure.
// Optional feature: define ALU_MUL_EN to build the iterative multiplier;
// without it opcode 9 is treated as reserved.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid, in_ready   input handshake; a, b, op captured on accept
//   a, b, op             operands and opcode
//   out_valid, out_ready output handshake
//   result, flag_n/z/v/c registered result and flags
//   illegal              registered; op was reserved
//   busy                 high in any state other than IDLE
module alu_registrada
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_c,
    output logic             illegal,
    output logic             busy
);

    alu_state_t       r_state;
    logic [WIDTH-1:0] r_result;
    alu_flags_t       r_flags;
    logic             r_illegal;

    logic             w_accept;
    logic             w_start_mul;
    logic [WIDTH-1:0] w_alu_result;
    alu_flags_t       w_alu_flags;
    logic             w_alu_illegal;

    // In DONE the slot frees up in the same cycle the consumer takes the result.
    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);

    assign result  = r_result;
    assign flag_n  = r_flags.n;
    assign flag_z  = r_flags.z;
    assign flag_v  = r_flags.v;
    assign flag_c  = r_flags.c;
    assign illegal = r_illegal;

    alu_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .i_a      (a),
        .i_b      (b),
        .i_op     (alu_op_t'(op)),
        .o_result (w_alu_result),
        .o_flags  (w_alu_flags),
        .o_illegal(w_alu_illegal)
    );

`ifdef ALU_MUL_EN
    localparam int unsigned SHW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mplier;
    logic [SHW-1:0]     r_count;
    logic [2*WIDTH-1:0] w_prod_next;
    logic               w_mul_last;
    alu_flags_t         w_mul_flags;

    assign w_start_mul = (op == 4'(OP_MUL));
    assign w_prod_next = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    assign w_mul_last  = (r_count == SHW'(WIDTH - 1));
    assign w_mul_flags = '{n: w_prod_next[WIDTH-1],
                           z: (w_prod_next[WIDTH-1:0] == '0),
                           v: 1'b0,
                           c: (w_prod_next[2*WIDTH-1:WIDTH] != '0)};

    // Shift-add multiplier: multiplicand moves left, multiplier moves right,
    // partial product accumulates one bit per clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
            r_count  <= '0;
        end else if (w_accept && w_start_mul) begin
            r_mcand  <= {WIDTH'(0), a};
            r_prod   <= '0;
            r_mplier <= b;
            r_count  <= '0;
        end else if (r_state == ST_MUL_BUSY) begin
            r_prod   <= w_prod_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + SHW'(1);
        end
    end
`else
    assign w_start_mul = 1'b0;
`endif

    // Control FSM and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_result  <= '0;
            r_flags   <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        if (w_start_mul) begin
                            r_state <= ST_MUL_BUSY;
                        end else begin
                            r_state   <= ST_DONE;
                            r_result  <= w_alu_result;
                            r_flags   <= w_alu_flags;
                            r_illegal <= w_alu_illegal;
                        end
                    end else if ((r_state == ST_DONE) && out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
`ifdef ALU_MUL_EN
                ST_MUL_BUSY: begin
                    if (w_mul_last) begin
                        r_state   <= ST_DONE;
                        r_result  <= w_prod_next[WIDTH-1:0];
                        r_flags   <= w_mul_flags;
                        r_illegal <= 1'b0;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_registrada.sv
// Scoreboard bench for alu_registrada (WIDTH=8): the driver pushes the
// expected response of each accepted operation, a negedge monitor compares
// whatever the DUT presents against the head of the queue.
module tb_alu_registrada;

    localparam int W = 8;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_n, flag_z, flag_v, flag_c;
    logic         illegal;
    logic         busy;

    alu_registrada #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .flag_n   (flag_n),
        .flag_z   (flag_z),
        .flag_v   (flag_v),
        .flag_c   (flag_c),
        .illegal  (illegal),
        .busy     (busy)
    );

    typedef struct {
        int r;
        int n, z, v, c, ill;
        int acc;
        int lat;
    } exp_t;

    exp_t q[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   cyc      = 0;
    int   rdy_mode = 0;  // 0: always ready, 1: random, 2: never ready

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, expv, $time);
        end
    endtask

    // Reference model written from the opcode rules with plain integer math.
    function automatic exp_t model(input int o, input int x, input int y);
        exp_t e;
        int sh, sx, sy, s;
        sh = y % W;
        sx = (x >= 128) ? x - 256 : x;
        sy = (y >= 128) ? y - 256 : y;
        e.r = 0; e.c = 0; e.v = 0; e.ill = 0;
        case (o)
            0: begin s = x + y; e.r = s % 256; e.c = s / 256;
                     s = sx + sy; e.v = (s > 127 || s < -128) ? 1 : 0; end
            1: begin e.r = (x - y + 256) % 256; e.c = (x >= y) ? 1 : 0;
                     s = sx - sy; e.v = (s > 127 || s < -128) ? 1 : 0; end
            2: e.r = x & y;
            3: e.r = x | y;
            4: e.r = x ^ y;
            5: e.r = 255 - x;
            6: begin e.r = (x << sh) % 256; e.c = (sh != 0) ? (x >> (W - sh)) & 1 : 0; end
            7: begin e.r = x >> sh; e.c = (sh != 0) ? (x >> (sh - 1)) & 1 : 0; end
            8: begin e.r = (sx >>> sh) & 255; e.c = (sh != 0) ? (x >> (sh - 1)) & 1 : 0; end
            9: begin
                if (MUL_EN) begin e.r = (x * y) % 256; e.c = (x * y >= 256) ? 1 : 0; end
                else e.ill = 1;
            end
            10: e.r = y;
            default: e.ill = 1;
        endcase
        e.n   = (e.r >= 128) ? 1 : 0;
        e.z   = (e.r == 0) ? 1 : 0;
        e.lat = (o == 9 && MUL_EN) ? W + 1 : 1;
        e.acc = 0;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input int o, input int x, input int y);
        int   n;
        exp_t e;
        n = 0;
        op = 4'(o); a = 8'(x); b = 8'(y); in_valid = 1'b1;
        forever begin
            @(negedge clk); #1;
            if (in_ready) begin
                e = model(o, x, y);
                e.acc = cyc;
                q.push_back(e);
                break;
            end
            n++;
            if (n > 200) begin
                n_cmp++; n_bad++;
                $display("FAIL accept_timeout: op %0d never accepted", o);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); op = 4'($urandom);
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d results never delivered", q.size());
            q.delete();
        end
    endtask

    // Consumer: drives out_ready according to rdy_mode.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                2:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compares presented outputs and handshake state against the queue.
    always @(negedge clk) begin : mon
        int ev;
        if (!reset) begin
            ev = (q.size() > 0) ? ((cyc - q[0].acc >= q[0].lat) ? 1 : 0) : 0;
            check("out_valid", int'(out_valid), ev);
            if (ev != 0) begin
                check("result",  int'(result),  q[0].r);
                check("flag_n",  int'(flag_n),  q[0].n);
                check("flag_z",  int'(flag_z),  q[0].z);
                check("flag_v",  int'(flag_v),  q[0].v);
                check("flag_c",  int'(flag_c),  q[0].c);
                check("illegal", int'(illegal), q[0].ill);
            end
            check("in_ready", int'(in_ready),
                  (q.size() == 0) ? 1 : ((ev != 0) ? int'(out_ready) : 0));
            check("busy", int'(busy), (q.size() > 0) ? 1 : 0);
            if (ev != 0 && out_ready) void'(q.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_result",  int'(result),  0);
        check("rst_flags",   int'({flag_n, flag_z, flag_v, flag_c}), 0);
        check("rst_illegal", int'(illegal), 0);
        @(posedge clk); #1;

        // Directed cases, consumer always ready.
        issue(0, 'hB5, 'hAB);
        issue(1, 'h05, 'h05);
        issue(1, 'h00, 'h01);
        issue(6, 'h81, 1);
        issue(8, 'h80, 3);
        issue(7, 'h5A, 0);
        issue(9, 'h10, 'h10);
        issue(9, 'h0D, 'h0B);
        issue(15, 'h12, 'h34);
        issue(10, 'h12, 'h00);
        issue(5, 'h00, 'h77);
        wait_empty();

        // Backpressure: ADD held for several cycles, XOR waiting behind it.
        rdy_mode = 2;
        @(posedge clk); #1;
        issue(0, 'h7F, 'h01);
        fork
            issue(4, 'hF0, 'h3C);
            begin
                repeat (5) @(posedge clk);
                rdy_mode = 0;
            end
        join
        wait_empty();

        // Randomized traffic with random backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 120; i++) begin
            issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rdy_mode = 0;
        wait_empty();

        // Reset in the middle of a multiply aborts it.
        issue(9, 'hFF, 'hFF);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_in_ready",  int'(in_ready),  1);
        check("abort_result",    int'(result),    0);
        check("abort_illegal",   int'(illegal),   0);
        @(posedge clk); #1;
        issue(3, 'hA0, 'h05);
        wait_empty();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
